// File: rtl/param_shift_register.sv
// Parametrised hold/load/shift/rotate operand register with start/busy/done handshake.
// Optional carry output when PARAM_SHIFT_REGISTER_CARRY_EN is defined.
`timescale 1ns/1ps
module param_shift_register #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              Tx,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] in,
    input  logic [AMT_W-1:0]        amt,
    output logic signed [WIDTH-1:0] out,
    output logic                    busy,
    output logic                    done
`ifdef PARAM_SHIFT_REGISTER_CARRY_EN
    ,
    output logic                    carry
`endif
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHR  = 3'b010,
        OP_SHL  = 3'b011,
        OP_CLR  = 3'b100,
        OP_SHRA = 3'b101,
        OP_ROR  = 3'b110,
        OP_ROL  = 3'b111
    } op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [AMT_W-1:0] AMT_ONE = {{(AMT_W-1){1'b0}}, 1'b1};

    state_t           state;
    op_t              op_q;
    logic [AMT_W-1:0] count;
    op_t              op_in;
    logic             accept;

    assign op_in  = op_t'(Tx);
    assign accept = start & ~busy;

    function automatic logic is_shift_op(input op_t op);
        return (op != OP_HOLD) && (op != OP_LOAD) && (op != OP_CLR);
    endfunction

    // One 1-bit step of the selected shift/rotate; multi-bit amounts iterate this.
    function automatic logic signed [WIDTH-1:0] step_val(input op_t op,
                                                         input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] r;
        r = v;
        case (op)
            OP_SHR:  r = {1'b0, v[WIDTH-1:1]};
            OP_SHL:  r = {v[WIDTH-2:0], 1'b0};
            OP_SHRA: r = {v[WIDTH-1], v[WIDTH-1:1]};
            OP_ROR:  r = {v[0], v[WIDTH-1:1]};
            OP_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
            default: r = v;
        endcase
        return r;
    endfunction

`ifdef PARAM_SHIFT_REGISTER_CARRY_EN
    function automatic logic shifted_out(input op_t op, input logic signed [WIDTH-1:0] v);
        logic b;
        case (op)
            OP_SHL, OP_ROL: b = v[WIDTH-1];
            default:        b = v[0];
        endcase
        return b;
    endfunction
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= OP_HOLD;
            count <= '0;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef PARAM_SHIFT_REGISTER_CARRY_EN
            carry <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= op_in;
                        if (!is_shift_op(op_in) || amt == '0) begin
                            count <= '0;
                            done  <= 1'b1;
                            case (op_in)
                                OP_LOAD: out <= in;
                                OP_CLR:  out <= '0;
                                default: ;
                            endcase
`ifdef PARAM_SHIFT_REGISTER_CARRY_EN
                            if (op_in == OP_LOAD || op_in == OP_CLR)
                                carry <= 1'b0;
`endif
                        end else begin
                            // Accept edge already performs the first step.
                            out   <= step_val(op_in, out);
                            count <= amt - AMT_ONE;
`ifdef PARAM_SHIFT_REGISTER_CARRY_EN
                            carry <= shifted_out(op_in, out);
`endif
                            if (amt == AMT_ONE) begin
                                done <= 1'b1;
                            end else begin
                                state <= SHIFT;
                                busy  <= 1'b1;
                            end
                        end
                    end
                end
                SHIFT: begin
                    out   <= step_val(op_q, out);
                    count <= count - AMT_ONE;
`ifdef PARAM_SHIFT_REGISTER_CARRY_EN
                    carry <= shifted_out(op_q, out);
`endif
                    if (count == AMT_ONE) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_shift_register.sv
// Directed bench for param_shift_register with a closed-form reference model and
// per-cycle comparison, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_param_shift_register;
    localparam int W  = 8;
    localparam int AW = 4;
    localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHR = 3'd2, SHL = 3'd3,
                           CLR  = 3'd4, SHRA = 3'd5, ROR = 3'd6, ROL = 3'd7;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [2:0]          Tx = 3'd0;
    logic                start = 1'b0;
    logic signed [W-1:0] in = '0;
    logic [AW-1:0]       amt = '0;
    logic signed [W-1:0] out;
    logic                busy;
    logic                done;
`ifdef PARAM_SHIFT_REGISTER_CARRY_EN
    logic                carry;
`endif

    int errors = 0;
    int checks = 0;
    logic run_cmp = 1'b0;

    always #5 clk = ~clk;

    param_shift_register #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk  (clk),
        .rst  (rst),
        .Tx   (Tx),
        .start(start),
        .in   (in),
        .amt  (amt),
        .out  (out),
        .busy (busy),
        .done (done)
`ifdef PARAM_SHIFT_REGISTER_CARRY_EN
        ,
        .carry(carry)
`endif
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Value after shifting v by k positions in one go (closed form, not stepped).
    function automatic logic [W-1:0] shifted(input logic [2:0] op, input logic [W-1:0] v, input int k);
        logic [W-1:0] r;
        int rr;
        rr = k % W;
        r = v;
        case (op)
            SHR:  r = (k >= W) ? '0 : (v >> k);
            SHL:  r = (k >= W) ? '0 : (v << k);
            SHRA: begin
                if (k >= W) r = {W{v[W-1]}};
                else        r = $signed(v) >>> k;
            end
            ROR:  r = (v >> rr) | (v << (W - rr));
            ROL:  r = (v << rr) | (v >> (W - rr));
            default: r = v;
        endcase
        return r;
    endfunction

    // Bit leaving the register on step k (1-based) of a shift starting from v.
    function automatic logic cout(input logic [2:0] op, input logic [W-1:0] v, input int k);
        logic b;
        b = 1'b0;
        case (op)
            SHR:  b = (k - 1 < W) ? v[k-1] : 1'b0;
            SHRA: b = (k - 1 < W) ? v[k-1] : v[W-1];
            SHL:  b = (k <= W) ? v[W-k] : 1'b0;
            ROR:  b = v[(k-1) % W];
            ROL:  b = v[W-1-((k-1) % W)];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    logic [W-1:0] m_out;
    logic         m_busy, m_done, m_carry;
    logic [W-1:0] q_val[$];
    logic         q_cy[$];
    logic [W-1:0] m_v0;
    int           m_n;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out = '0; m_busy = 1'b0; m_done = 1'b0; m_carry = 1'b0;
            q_val.delete(); q_cy.delete();
        end else begin
            m_done = 1'b0;
            if (q_val.size() > 0) begin
                m_out   = q_val.pop_front();
                m_carry = q_cy.pop_front();
                if (q_val.size() == 0) m_done = 1'b1;
            end else if (start) begin
                m_n = int'(amt);
                if (Tx == LOAD) begin
                    m_out = in; m_carry = 1'b0; m_done = 1'b1;
                end else if (Tx == CLR) begin
                    m_out = '0; m_carry = 1'b0; m_done = 1'b1;
                end else if (Tx == HOLD || m_n == 0) begin
                    m_done = 1'b1;
                end else begin
                    m_v0 = m_out;
                    for (int k = 1; k <= m_n; k++) begin
                        q_val.push_back(shifted(Tx, m_v0, k));
                        q_cy.push_back(cout(Tx, m_v0, k));
                    end
                    m_out   = q_val.pop_front();
                    m_carry = q_cy.pop_front();
                    if (q_val.size() == 0) m_done = 1'b1;
                end
            end
            m_busy = (q_val.size() > 0);
        end
    end

    always @(negedge clk) begin
        if (run_cmp && !rst) begin
            check("model_out", out, m_out);
            check("model_busy", {7'b0, busy}, {7'b0, m_busy});
            check("model_done", {7'b0, done}, {7'b0, m_done});
`ifdef PARAM_SHIFT_REGISTER_CARRY_EN
            check("model_carry", {7'b0, carry}, {7'b0, m_carry});
`endif
        end
    end

    task automatic issue(input logic [2:0] op, input int a, input logic [W-1:0] d);
        @(negedge clk);
        Tx = op; amt = AW'(a); in = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; Tx = LOAD; in = 8'hEE;
    endtask

    task automatic step_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_out", out, 8'h00);
        check("reset_busy", {7'b0, busy}, 8'h00);
        check("reset_done", {7'b0, done}, 8'h00);
        run_cmp = 1'b1;

        issue(LOAD, 0, 8'hA5);
        check("load_out", out, 8'hA5);
        check("load_busy", {7'b0, busy}, 8'h00);
        check("load_done", {7'b0, done}, 8'h01);
        step_n(1);
        check("load_done_off", {7'b0, done}, 8'h00);

        issue(SHR, 3, 8'h00);
        check("shr_1", out, 8'h52);
        check("shr_busy1", {7'b0, busy}, 8'h01);
        step_n(1);
        check("shr_2", out, 8'h29);
        step_n(1);
        check("shr_3", out, 8'h14);
        check("shr_busy_end", {7'b0, busy}, 8'h00);
        check("shr_done", {7'b0, done}, 8'h01);
`ifdef PARAM_SHIFT_REGISTER_CARRY_EN
        check("shr_carry", {7'b0, carry}, 8'h01);
`endif

        issue(LOAD, 0, 8'h90);
        issue(SHRA, 2, 8'h00);
        check("shra_1", out, 8'hC8);
        step_n(1);
        check("shra_2", out, 8'hE4);
        issue(ROL, 9, 8'h00);
        check("rol9_1", out, 8'hC9);
        step_n(8);
        check("rol9_final", out, 8'hC9);
        check("rol9_done", {7'b0, done}, 8'h01);

        issue(LOAD, 0, 8'h01);
        issue(SHL, 5, 8'h00);
        @(negedge clk);
        Tx = LOAD; in = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ignore_mid", out, 8'h04);
        step_n(3);
        check("ignore_final", out, 8'h20);
        check("ignore_done", {7'b0, done}, 8'h01);

        issue(LOAD, 0, 8'h01);
        issue(SHL, 7, 8'h00);
        step_n(4);
        check("pre_rst_out", out, 8'h20);
        check("pre_rst_busy", {7'b0, busy}, 8'h01);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out", out, 8'h00);
        check("async_rst_busy", {7'b0, busy}, 8'h00);
        check("async_rst_done", {7'b0, done}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        issue(LOAD, 0, 8'h5A);
        check("post_rst_load", out, 8'h5A);

        @(negedge clk);
        Tx = CLR; start = 1'b1;
        @(posedge clk); #1;
        check("b2b_clr", out, 8'h00);
        check("b2b_done1", {7'b0, done}, 8'h01);
        Tx = LOAD; in = 8'h3C;
        @(posedge clk); #1;
        check("b2b_load", out, 8'h3C);
        check("b2b_done2", {7'b0, done}, 8'h01);
        Tx = SHL; amt = '0;
        @(posedge clk); #1;
        check("b2b_shl0", out, 8'h3C);
        check("b2b_done3", {7'b0, done}, 8'h01);
        check("b2b_busy", {7'b0, busy}, 8'h00);
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b_done_off", {7'b0, done}, 8'h00);

        @(negedge clk);
        Tx = LOAD; in = 8'h77; start = 1'b0;
        @(posedge clk); #1;
        check("nostart_hold", out, 8'h3C);
        issue(HOLD, 0, 8'h11);
        check("hold_out", out, 8'h3C);
        check("hold_done", {7'b0, done}, 8'h01);

        issue(LOAD, 0, 8'h80);
        issue(SHRA, 12, 8'h00);
        step_n(11);
        check("shra12", out, 8'hFF);
`ifdef PARAM_SHIFT_REGISTER_CARRY_EN
        check("shra12_carry", {7'b0, carry}, 8'h01);
`endif
        issue(LOAD, 0, 8'h01);
        issue(ROR, 9, 8'h00);
        step_n(8);
        check("ror9", out, 8'h80);
        issue(LOAD, 0, 8'hFF);
        issue(SHR, 15, 8'h00);
        step_n(14);
        check("shr15", out, 8'h00);
        check("shr15_done", {7'b0, done}, 8'h01);

        step_n(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
